// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } mem_rsp_t;

endpackage

// File: rtl/sram_sp.sv
// Single-port word RAM with per-byte write enables and registered read data.
// Read data reflects the word contents before a write in the same cycle and is
// held while the port is disabled.
module sram_sp #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Byte-masked write and synchronous read on enabled cycles only.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one word request at a time, waits a fixed
// number of cycles, accesses the on-chip RAM and returns a response.
//
// state  | meaning
// IDLE   | no transaction in progress, ready for a request
// WAIT   | counting wait states before the RAM access
// ACCESS | RAM enabled for one cycle (unless the request faulted)
// RESP   | response presented; may accept the next request on handshake
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam state_e      FIRST_ST  = (WAIT_CYCLES > 0) ? WAIT : ACCESS;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  mem_req_t    req_q, req_d;
  logic        err_q, err_d;
  // Set when the pending response carries RAM read data.
  logic        rd_q, rd_d;

  logic        accept;
  logic [31:0] offset;
  logic        fault;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  mem_rsp_t    rsp;

  // Addresses below BASE_ADDR wrap to a large offset and fail the range test.
  assign offset = req_q.addr - BASE_ADDR;
  assign fault  = (req_q.addr[1:0] != 2'b00) || ((offset >> (AW + 2)) != 32'd0);

  assign req_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;

  // State, wait counter, captured request and response flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  // Next-state, request capture and RAM control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    err_d   = err_q;
    rd_d    = rd_q;
    ram_en  = 1'b0;
    ram_we  = 4'b0000;

    if (accept) begin
      req_d.write = req_write;
      req_d.addr  = req_addr;
      req_d.wdata = req_wdata;
      req_d.strb  = req_strb;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = FIRST_ST;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS: begin
        ram_en  = !fault;
        ram_we  = (!fault && req_q.write) ? req_q.strb : 4'b0000;
        err_d   = fault;
        rd_d    = !fault && !req_q.write;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (req_valid) begin
            state_d = FIRST_ST;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sram_sp #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (offset[AW+1:2]),
    .wdata (req_q.wdata),
    .rdata (ram_rdata)
  );

  // Response view; RAM read data is held while the port stays disabled in RESP.
  always_comb begin
    rsp.rdata = ((state_q == RESP) && rd_q) ? ram_rdata : 32'd0;
    rsp.error = (state_q == RESP) && err_q;
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp.rdata;
  assign rsp_error = rsp.error;

endmodule
